// File: rtl/alu_arbiter_if.sv
// rtl/alu_arbiter_if.sv - requester, shared-ALU and response signals of the ALU arbiter
interface alu_arbiter_if #(
  parameter int W = 32
);
  // Requester 0
  logic         req0_valid;
  logic         req0_ready;
  logic [W-1:0] req0_a;
  logic [W-1:0] req0_b;
  logic [3:0]   req0_sel;
  // Requester 1
  logic         req1_valid;
  logic         req1_ready;
  logic [W-1:0] req1_a;
  logic [W-1:0] req1_b;
  logic [3:0]   req1_sel;
  // Shared ALU drive and its registered result
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [3:0]   alu_sel;
  logic [W-1:0] alu_out;
  logic         alu_ovf;
  // Response
  logic         rsp_valid;
  logic         rsp_ready;
  logic         rsp_id;
  logic         rsp_err;
  logic         rsp_ovf;
  logic [W-1:0] rsp_data;
  logic         busy;

  // Environment side: requesters, ALU and response consumer
  modport master (
    output req0_valid, req0_a, req0_b, req0_sel,
    output req1_valid, req1_a, req1_b, req1_sel,
    output alu_out, alu_ovf, rsp_ready,
    input  req0_ready, req1_ready,
    input  alu_a, alu_b, alu_sel,
    input  rsp_valid, rsp_id, rsp_err, rsp_ovf, rsp_data, busy
  );

  // Arbiter side
  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sel,
    input  req1_valid, req1_a, req1_b, req1_sel,
    input  alu_out, alu_ovf, rsp_ready,
    output req0_ready, req1_ready,
    output alu_a, alu_b, alu_sel,
    output rsp_valid, rsp_id, rsp_err, rsp_ovf, rsp_data, busy
  );
endinterface

// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - round-robin arbiter sharing one registered ALU between two requesters
module alu_arbiter #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  alu_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  // alu_sel value that makes the ALU hold its result
  localparam logic [3:0] SEL_HOLD = 4'b1111;
  // Highest legal opcode (SUB)
  localparam logic [3:0] SEL_MAX  = 4'd4;
  // The ALU result is sampled after the operands have been held for three cycles
  localparam logic [1:0] CNT_LAST = 2'd2;

  state_t       r_state;
  logic [1:0]   r_cnt;
  logic         r_last;          // requester served most recently
  logic         r_out_of_reset;  // keeps ready low in the first cycle after reset release
  logic [W-1:0] r_alu_a;
  logic [W-1:0] r_alu_b;
  logic [3:0]   r_alu_sel;
  logic         r_rsp_valid;
  logic         r_rsp_id;
  logic         r_rsp_err;
  logic         r_rsp_ovf;
  logic [W-1:0] r_rsp_data;
  logic         r_busy;

  logic         w_open;
  logic         w_grant0;
  logic         w_grant1;
  logic         w_xfer0;
  logic         w_xfer1;
  logic         w_xfer;
  logic [W-1:0] w_a;
  logic [W-1:0] w_b;
  logic [3:0]   w_sel;

  // Acceptance is only possible in IDLE; with both requesters valid the one not
  // served last wins, so the grant is re-evaluated every IDLE cycle without locking.
  assign w_open   = r_out_of_reset && (r_state == IDLE);
  assign w_grant0 = bus.req0_valid && (!bus.req1_valid || r_last);
  assign w_grant1 = bus.req1_valid && (!bus.req0_valid || !r_last);

  assign bus.req0_ready = w_open && w_grant0;
  assign bus.req1_ready = w_open && w_grant1;

  assign w_xfer0 = bus.req0_valid && bus.req0_ready;
  assign w_xfer1 = bus.req1_valid && bus.req1_ready;
  assign w_xfer  = w_xfer0 || w_xfer1;

  assign w_a   = w_xfer1 ? bus.req1_a   : bus.req0_a;
  assign w_b   = w_xfer1 ? bus.req1_b   : bus.req0_b;
  assign w_sel = w_xfer1 ? bus.req1_sel : bus.req0_sel;

  assign bus.alu_a     = r_alu_a;
  assign bus.alu_b     = r_alu_b;
  assign bus.alu_sel   = r_alu_sel;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_id    = r_rsp_id;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.rsp_ovf   = r_rsp_ovf;
  assign bus.rsp_data  = r_rsp_data;
  assign bus.busy      = r_busy;

  // Operation FSM: accept, drive the ALU for three cycles, hold the response until taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= IDLE;
      r_cnt          <= 2'd0;
      r_last         <= 1'b1;
      r_out_of_reset <= 1'b0;
      r_alu_a        <= '0;
      r_alu_b        <= '0;
      r_alu_sel      <= SEL_HOLD;
      r_rsp_valid    <= 1'b0;
      r_rsp_id       <= 1'b0;
      r_rsp_err      <= 1'b0;
      r_rsp_ovf      <= 1'b0;
      r_rsp_data     <= '0;
      r_busy         <= 1'b0;
    end else begin
      r_out_of_reset <= 1'b1;
      case (r_state)
        IDLE: begin
          if (w_xfer) begin
            r_rsp_id <= w_xfer1;
            r_busy   <= 1'b1;
            if (w_sel <= SEL_MAX) begin
              r_state   <= EXEC;
              r_cnt     <= 2'd0;
              r_alu_a   <= w_a;
              r_alu_b   <= w_b;
              r_alu_sel <= w_sel;
            end else begin
              // Illegal opcode: answer at once, the ALU is never driven
              r_state     <= RESP;
              r_rsp_valid <= 1'b1;
              r_rsp_err   <= 1'b1;
              r_rsp_ovf   <= 1'b0;
              r_rsp_data  <= '0;
            end
          end
        end
        EXEC: begin
          if (r_cnt == CNT_LAST) begin
            r_state     <= RESP;
            r_rsp_valid <= 1'b1;
            r_rsp_err   <= 1'b0;
            r_rsp_ovf   <= bus.alu_ovf;
            r_rsp_data  <= bus.alu_out;
            r_alu_a     <= '0;
            r_alu_b     <= '0;
            r_alu_sel   <= SEL_HOLD;
          end else begin
            r_cnt <= r_cnt + 2'd1;
          end
        end
        RESP: begin
          if (bus.rsp_ready) begin
            r_state     <= IDLE;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_last      <= r_rsp_id;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_rsp_valid <= 1'b0;
          r_busy      <= 1'b0;
          r_alu_a     <= '0;
          r_alu_b     <= '0;
          r_alu_sel   <= SEL_HOLD;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - directed self-checking bench for alu_arbiter with a registered ALU model
module tb_alu_arbiter;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  alu_arbiter_if #(.W(32)) bus ();

  alu_arbiter #(.W(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Shared ALU: registered result, holds while alu_sel is 4'b1111
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.alu_out <= 32'd0;
      bus.alu_ovf <= 1'b0;
    end else if (bus.alu_sel != 4'hF) begin
      case (bus.alu_sel)
        4'd0: begin bus.alu_out <= bus.alu_a & bus.alu_b; bus.alu_ovf <= 1'b0; end
        4'd1: begin bus.alu_out <= bus.alu_a | bus.alu_b; bus.alu_ovf <= 1'b0; end
        4'd2: begin bus.alu_out <= bus.alu_a ^ bus.alu_b; bus.alu_ovf <= 1'b0; end
        4'd3: begin
          bus.alu_out <= bus.alu_a + bus.alu_b;
          bus.alu_ovf <= add_ovf(bus.alu_a, bus.alu_b);
        end
        4'd4: begin
          bus.alu_out <= bus.alu_a - bus.alu_b;
          bus.alu_ovf <= sub_ovf(bus.alu_a, bus.alu_b);
        end
        default: begin bus.alu_out <= 32'd0; bus.alu_ovf <= 1'b0; end
      endcase
    end
  end

  function automatic logic add_ovf(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    s = a + b;
    return (a[31] == b[31]) && (s[31] != a[31]);
  endfunction

  function automatic logic sub_ovf(input logic [31:0] a, input logic [31:0] b);
    logic [31:0] s;
    s = a - b;
    return (a[31] != b[31]) && (s[31] != a[31]);
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic drive_req(input int n, input logic [31:0] a, input logic [31:0] b,
                           input logic [3:0] sel);
    if (n == 0) begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_sel = sel; bus.req0_valid = 1'b1;
    end else begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_sel = sel; bus.req1_valid = 1'b1;
    end
  endtask

  // Waits for the transfer edge of requester n, drops its valid just after it
  task automatic wait_xfer(input int n);
    bit done;
    done = 1'b0;
    for (int c = 0; c < 30 && !done; c++) begin
      @(negedge clk);
      if ((n == 0 && bus.req0_ready) || (n == 1 && bus.req1_ready)) begin
        @(posedge clk);
        #1;
        if (n == 0) bus.req0_valid = 1'b0;
        else        bus.req1_valid = 1'b0;
        done = 1'b1;
      end
    end
    if (!done) check("xfer_timeout", 32'd0, 32'd1);
  endtask

  // Called right after the transfer edge; nlow = cycles rsp_valid must stay low
  task automatic expect_rsp(input string tag, input int nlow, input logic [3:0] exp_sel,
                            input logic exp_id, input logic [31:0] exp_data,
                            input logic exp_err, input logic exp_ovf);
    for (int i = 0; i < nlow; i++) begin
      @(negedge clk);
      check({tag, "_wait_valid"}, 32'(bus.rsp_valid), 32'd0);
      check({tag, "_alu_sel"}, 32'(bus.alu_sel), 32'(exp_sel));
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
    check({tag, "_data"}, bus.rsp_data, exp_data);
    check({tag, "_id"}, 32'(bus.rsp_id), 32'(exp_id));
    check({tag, "_err"}, 32'(bus.rsp_err), 32'(exp_err));
    check({tag, "_ovf"}, 32'(bus.rsp_ovf), 32'(exp_ovf));
    check({tag, "_alu_hold"}, 32'(bus.alu_sel), 32'hF);
    @(posedge clk);
    #1;
  endtask

  initial begin
    bit found;
    n_checks = 0;
    n_fail   = 0;
    rst_n          = 1'b0;
    bus.rsp_ready  = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_a = 32'd0; bus.req0_b = 32'd0; bus.req0_sel = 4'd0;
    bus.req1_valid = 1'b0; bus.req1_a = 32'd0; bus.req1_b = 32'd0; bus.req1_sel = 4'd0;

    // Reset state, with a request pending that must not see ready
    repeat (3) @(posedge clk);
    bus.req0_valid = 1'b1;
    @(negedge clk);
    check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_alu_sel", 32'(bus.alu_sel), 32'hF);
    check("rst_alu_a", bus.alu_a, 32'd0);
    check("rst_rsp_data", bus.rsp_data, 32'd0);
    check("rst_ready0", 32'(bus.req0_ready), 32'd0);
    bus.req0_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Single ADD and overflow cases
    drive_req(0, 32'd5, 32'd7, 4'd3);
    wait_xfer(0);
    expect_rsp("add", 3, 4'd3, 1'b0, 32'd12, 1'b0, 1'b0);
    @(negedge clk);
    check("add_idle_busy", 32'(bus.busy), 32'd0);

    drive_req(1, 32'h7FFF_FFFF, 32'd1, 4'd3);
    wait_xfer(1);
    expect_rsp("add_ovf", 3, 4'd3, 1'b1, 32'h8000_0000, 1'b0, 1'b1);

    drive_req(0, 32'd3, 32'd5, 4'd4);
    wait_xfer(0);
    expect_rsp("sub", 3, 4'd4, 1'b0, 32'hFFFF_FFFE, 1'b0, 1'b0);

    drive_req(1, 32'h8000_0000, 32'd1, 4'd4);
    wait_xfer(1);
    expect_rsp("sub_ovf", 3, 4'd4, 1'b1, 32'h7FFF_FFFF, 1'b0, 1'b1);

    drive_req(0, 32'hA0A0_0000, 32'h0505_00FF, 4'd1);
    wait_xfer(0);
    expect_rsp("or", 3, 4'd1, 1'b0, 32'hA5A5_00FF, 1'b0, 1'b0);

    // Illegal opcodes: immediate response, ALU never driven
    drive_req(1, 32'd9, 32'd9, 4'b1000);
    wait_xfer(1);
    expect_rsp("illegal8", 0, 4'hF, 1'b1, 32'd0, 1'b1, 1'b0);

    drive_req(0, 32'd1, 32'd1, 4'd5);
    wait_xfer(0);
    expect_rsp("illegal5", 0, 4'hF, 1'b0, 32'd0, 1'b1, 1'b0);

    // Backpressure with the other requester pending
    bus.rsp_ready = 1'b0;
    drive_req(0, 32'h1234_5678, 32'hFFFF_FFFF, 4'd2);
    wait_xfer(0);
    drive_req(1, 32'd2, 32'd3, 4'd3);
    found = 1'b0;
    for (int c = 0; c < 10 && !found; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) found = 1'b1;
    end
    check("bp_rsp_arrived", 32'(found), 32'd1);
    for (int c = 0; c < 10; c++) begin
      check("bp_valid", 32'(bus.rsp_valid), 32'd1);
      check("bp_data", bus.rsp_data, 32'hEDCB_A987);
      check("bp_ready0", 32'(bus.req0_ready), 32'd0);
      check("bp_ready1", 32'(bus.req1_ready), 32'd0);
      check("bp_alu_sel", 32'(bus.alu_sel), 32'hF);
      check("bp_alu_a", bus.alu_a, 32'd0);
      @(negedge clk);
    end
    bus.rsp_ready = 1'b1;
    wait_xfer(1);
    expect_rsp("after_bp", 3, 4'd3, 1'b1, 32'd5, 1'b0, 1'b0);

    // Reset during EXEC with cnt == 1 abandons the operation
    drive_req(0, 32'd5, 32'd7, 4'd3);
    wait_xfer(0);
    bus.req1_valid = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy", 32'(bus.busy), 32'd0);
    check("mid_rst_valid", 32'(bus.rsp_valid), 32'd0);
    check("mid_rst_alu_sel", 32'(bus.alu_sel), 32'hF);
    check("mid_rst_alu_a", bus.alu_a, 32'd0);
    check("mid_rst_alu_b", bus.alu_b, 32'd0);
    check("mid_rst_ready1", 32'(bus.req1_ready), 32'd0);
    check("mid_rst_rsp_id", 32'(bus.rsp_id), 32'd0);
    check("mid_rst_rsp_data", bus.rsp_data, 32'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Contention after reset: req0 wins first, then strict alternation
    drive_req(0, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd0);
    drive_req(1, 32'hF0F0_F0F0, 32'hFF00_FF00, 4'd2);
    for (int k = 0; k < 4; k++) begin
      found = 1'b0;
      for (int c = 0; c < 20 && !found; c++) begin
        @(negedge clk);
        if (bus.rsp_valid) found = 1'b1;
      end
      check("rr_rsp_arrived", 32'(found), 32'd1);
      check("rr_id", 32'(bus.rsp_id), 32'(k % 2));
      check("rr_data", bus.rsp_data, (k % 2 == 0) ? 32'hF000_F000 : 32'h0FF0_0FF0);
      if (k == 3) begin
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("final_busy", 32'(bus.busy), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  // Global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
